// File: rtl/axis_rr_packet_arbiter.sv
// axis_rr_packet_arbiter
// N-input AXI-Stream packet arbiter. It merges several stream sources onto one
// downstream AXIS channel. Grant is round-robin and is computed with a
// left-thermometer mask built from the last winner. A grant is held for a whole
// packet and is released by the accepted beat that carries tlast. All m_* outputs
// come straight from flops.
//
// Optional feature: define AXIS_ARB_TID_EN to add m_tid, which carries the source
// index of each output beat.
//
// Handshake: a beat moves across an interface on a rising clk edge where valid
// and ready are both high. A source holds valid, data and last until that edge.
// The output register holds m_tdata and m_tlast stable while m_tvalid is high
// and m_tready is low. s_tready depends on state, grant_idx, m_tvalid and
// m_tready. It never depends on s_tvalid.
//
// busy is high exactly in the LOCK state, so it also serves as the FSM state
// observation point.

module axis_rr_packet_arbiter #(
  parameter int N  = 4,
  parameter int W  = 32,
  parameter int IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N-1:0]    s_tvalid,
  output logic [N-1:0]    s_tready,
  input  logic [N*W-1:0]  s_tdata,
  input  logic [N-1:0]    s_tlast,
  output logic            m_tvalid,
  input  logic            m_tready,
  output logic [W-1:0]    m_tdata,
  output logic            m_tlast,
`ifdef AXIS_ARB_TID_EN
  output logic [IW-1:0]   m_tid,
`endif
  output logic [IW-1:0]   grant_idx,
  output logic            busy
);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t        state;
  logic [IW-1:0] last;

  logic [N-1:0]  onehot_last;
  logic [N-1:0]  thermo_last;
  logic [N-1:0]  lo;
  logic [N-1:0]  pick;
  logic [IW-1:0] win;

  logic          out_free;
  logic          accept;
  logic [W-1:0]  sel_data;
  logic          sel_last;
  logic          sel_valid;

  // Round-robin winner. thermo_last has ones from the MSB down to bit 'last'.
  // Its complement keeps only the requesters below the last winner. The highest
  // of those wins. If there are none, the selection wraps to the highest
  // requester overall.
  always_comb begin
    onehot_last = N'(1) << last;
    thermo_last = ~(onehot_last - N'(1));
    lo          = s_tvalid & ~thermo_last;
    pick        = (lo != '0) ? lo : s_tvalid;
    win         = '0;
    for (int i = 0; i < N; i++) begin
      if (pick[i]) win = IW'(i);
    end
  end

  // Select the granted lane's beat and generate the single ready bit.
  always_comb begin
    sel_data  = '0;
    sel_last  = 1'b0;
    sel_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == IW'(i)) begin
        sel_data  = s_tdata[i*W +: W];
        sel_last  = s_tlast[i];
        sel_valid = s_tvalid[i];
      end
    end
    out_free = !m_tvalid || m_tready;
    s_tready = '0;
    if (state == LOCK) s_tready[grant_idx] = out_free;
    accept   = (state == LOCK) && sel_valid && out_free;
  end

  // Arbitration FSM. IDLE picks a winner. LOCK holds the grant until the beat
  // carrying tlast is accepted.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      last      <= '0;
      grant_idx <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (s_tvalid != '0) begin
            state     <= LOCK;
            grant_idx <= win;
            last      <= win;
            busy      <= 1'b1;
          end
        end
        LOCK: begin
          if (accept && sel_last) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Output register. It loads on an accepted beat, empties when the sink takes
  // the beat and no new beat arrives, and otherwise holds its contents.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tlast  <= 1'b0;
`ifdef AXIS_ARB_TID_EN
      m_tid    <= '0;
`endif
    end else if (accept) begin
      m_tvalid <= 1'b1;
      m_tdata  <= sel_data;
      m_tlast  <= sel_last;
`ifdef AXIS_ARB_TID_EN
      m_tid    <= grant_idx;
`endif
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

endmodule

// File: doc/axis_rr_packet_arbiter.md
Name: axis_rr_packet_arbiter

Overview:
- N-input AXI-Stream packet arbiter that shares one downstream AXIS channel between several stream sources, e.g. multiple generator instances feeding one sink.
- Grant is round-robin, computed with a left-thermometer mask: ones from the MSB down to a chosen bit position.
- Grant is locked for a whole packet and released on the accepted beat with tlast.
- Output is a single registered stage, so all m_* outputs are flop-driven.

Parameters:
- N, 4, number of slave inputs (2..16).
- W, 32, tdata width in bits.
- IW, $clog2(N), index width; used by the optional tid output.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- s_tvalid  in  N  per-input valid.
- s_tready  out  N  per-input ready; at most one bit high.
- s_tdata  in  N*W  packed data; input i occupies [i*W +: W].
- s_tlast  in  N  per-input end of packet.
- m_tvalid  out  1  output valid.
- m_tready  in  1  output ready.
- m_tdata  out  W  output data.
- m_tlast  out  1  output end of packet.
- grant_idx  out  IW  index of current or last granted input (status).
- busy  out  1  high while a packet is locked.

Behaviour:
- Reset values (reset_n=0 at a clk edge): state=IDLE, last=0, grant_idx=0, busy=0, m_tvalid=0, m_tdata=0, m_tlast=0, s_tready=0.
- State IDLE:
  - s_tready=0.
  - If s_tvalid==0, remain in IDLE.
  - Else compute:
    - lo = s_tvalid & ~thermo_left(onehot(last)), i.e. requesters with index < last.
    - win = highest set bit of lo if lo!=0, else highest set bit of s_tvalid.
  - Next cycle: state=LOCK, grant_idx=win, last=win, busy=1.
- State LOCK:
  - s_tready[grant_idx] = (!m_tvalid || m_tready); all other bits 0.
- Beat accept: a beat is accepted when s_tvalid[g] && s_tready[g]. On accept, the m_* register loads tdata/tlast on the next edge with m_tvalid=1. Latency is exactly 1 cycle from input handshake to output valid.
- Output register:
  - m_tvalid clears when m_tready && no new beat is accepted in the same cycle.
  - Full throughput when m_tready stays high: 1 beat/cycle.
  - Data is held stable while m_tvalid && !m_tready (AXIS rule).
- Packet end: accepting a beat with s_tlast=1 returns the state to IDLE and sets busy=0 on the next edge. Exactly 1 arbitration bubble cycle follows between packets.
- Rotation: the winner just served moves to lowest priority among the inputs below it. With all inputs requesting, the service order is 3,2,1,0,3,2,... (N=4).
- Single requester: the same input is regranted every packet, with a 1-cycle gap.
- Lock rule: input valid drop mid-packet does not release the lock. The arbiter waits in LOCK indefinitely for tlast.
- Single-beat packets (tlast on first beat) are legal and take 2 cycles per packet.
- Reset mid-packet: everything returns to reset values at once. The partial packet is dropped and no m_tlast is generated.
- Widths: thermo_left mask is N bits; the leftmost set bit selects the win index in IW bits.

Optional Feature:
- Macro AXIS_ARB_TID_EN.
- When defined: extra output port m_tid [IW-1:0] is registered alongside m_tdata and carries the source index of each beat; reset value 0.
- When undefined: the port and its flops are absent, and the block behaves identically otherwise.

Test Plan:
1. Reset: hold reset_n=0 for 3 clocks with all s_tvalid=1. Required: all outputs 0, no s_tready.
2. Round robin: N=4, all inputs send 2-beat packets continuously, m_tready=1. Required: grant order 3,2,1,0,3 with data from the matching lanes; 1 idle cycle between packets on m_tvalid.
3. Backpressure: input 1 only, 4-beat packet 0xA0..0xA3, m_tready toggling 1,0,0,1,... Required: no beat lost or duplicated, m_tdata stable while stalled, m_tlast only on 0xA3.
4. Lock: input 2 packet in progress, input 3 raises valid after beat 1. Required: input 3 gets no s_tready until input 2's tlast is accepted, then input 3 is granted next.
5. Reset mid-packet: reset_n low after beat 2 of a 5-beat packet. Required: next cycle m_tvalid=0, busy=0; after release, fresh arbitration picks the highest requester.
6. AXIS_ARB_TID_EN defined, scenario 2 repeated. Required: m_tid equals 3,2,1,0 per packet on every beat.
